// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register: control + data payload with valid/ready handshake,
// flush-by-bubble and an optional one-entry skid buffer that registers in_ready.
module pipe_stage_reg #(
    parameter int unsigned CTRL_W = 3,
    parameter int unsigned DATA_W = 69,
    parameter bit          SKID   = 1'b1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    state_e            state_q, state_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              in_xfer;
    logic              out_xfer;

    assign out_valid = (state_q != StEmpty);
    assign out_xfer  = out_valid & out_ready;
    assign in_xfer   = in_valid & in_ready & ~flush & ~RST;
    assign out_ctrl  = main_ctrl_q & {CTRL_W{out_valid}};
    assign out_data  = main_data_q;

    always_comb begin
        occupancy = 2'd0;
        unique case (state_q)
            StOne:   occupancy = 2'd1;
            StTwo:   occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            // Invalid slots keep an all-zero control field so no write enable can leak.
            state_d     = StEmpty;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (in_xfer) begin
                        state_d     = StOne;
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end
                end
                StOne: begin
                    if (in_xfer && (out_xfer || !SKID)) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end else if (in_xfer) begin
                        state_d     = StTwo;
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                    end else if (out_xfer) begin
                        state_d     = StEmpty;
                        main_ctrl_d = '0;
                    end
                end
                StTwo: begin
                    if (out_xfer) begin
                        state_d     = StOne;
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                        skid_ctrl_d = '0;
                    end
                end
                default: begin
                    state_d     = StEmpty;
                    main_ctrl_d = '0;
                    skid_ctrl_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StEmpty;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
        end
    end

    if (SKID) begin : g_skid_ready
        // Registered ready: accept unless the stage will be full after this edge.
        logic in_ready_q;
        always_ff @(posedge CLK) begin
            if (RST) begin
                in_ready_q <= 1'b1;
            end else begin
                in_ready_q <= (state_d != StTwo);
            end
        end
        assign in_ready = in_ready_q;
    end else begin : g_comb_ready
        assign in_ready = ~out_valid | out_ready;
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench: lane 0 runs SKID=1, lane 1 runs SKID=0, each against a queue model.
module tb_pipe_stage_reg;

    localparam int unsigned CW = 3;
    localparam int unsigned DW = 69;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    logic [1:0]          flush, in_valid, in_ready, out_valid, out_ready;
    logic [1:0][CW-1:0]  in_ctrl, out_ctrl;
    logic [1:0][DW-1:0]  in_data, out_data;
    logic [1:0][1:0]     occ;

    always #5 clk = ~clk;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b1)) u_skid (
        .CLK(clk), .RST(rst), .flush(flush[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_ctrl(in_ctrl[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_ctrl(out_ctrl[0]),
        .out_data(out_data[0]), .occupancy(occ[0])
    );

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b0)) u_comb (
        .CLK(clk), .RST(rst), .flush(flush[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_ctrl(in_ctrl[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_ctrl(out_ctrl[1]),
        .out_data(out_data[1]), .occupancy(occ[1])
    );

    ent_t       mq [2][$];
    logic [1:0] rdy_q;
    logic [1:0] acc;
    int         n_out [2];
    int         n_cmp;
    int         n_bad;
    bit         armed;
    logic       m_rdy, m_ix, m_ox;

    task automatic check(input string name, input int k, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s lane%0d: got %h expected %h at %0t", name, k, act, exp, $time);
        end
    endtask

    // Monitor: compare against the model, then advance the model to the coming edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            m_rdy = (k == 0) ? rdy_q[k] : ((mq[k].size() == 0) || out_ready[k]);
            if (armed) begin
                check("out_valid", k, DW'(out_valid[k]), DW'(mq[k].size() != 0));
                check("occupancy", k, DW'(occ[k]), DW'(mq[k].size()));
                check("in_ready", k, DW'(in_ready[k]), DW'(m_rdy));
                if (mq[k].size() != 0) begin
                    check("out_ctrl", k, DW'(out_ctrl[k]), DW'(mq[k][0].c));
                    check("out_data", k, out_data[k], mq[k][0].d);
                end else begin
                    check("bubble_ctrl", k, DW'(out_ctrl[k]), '0);
                end
            end
            m_ix = in_valid[k] && m_rdy && !flush[k] && !rst;
            m_ox = (mq[k].size() != 0) && out_ready[k];
            acc[k] = m_ix;
            if (rst) begin
                mq[k].delete();
                rdy_q[k] = 1'b1;
            end else begin
                if (m_ox) begin
                    void'(mq[k].pop_front());
                    n_out[k]++;
                end
                if (flush[k]) mq[k].delete();
                else if (m_ix) mq[k].push_back({in_ctrl[k], in_data[k]});
                rdy_q[k] = (mq[k].size() < 2);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        in_valid  = '0;
        flush     = '0;
        out_ready = '1;
    endtask

    // Upstream holds each word until the model says it was taken.
    task automatic stream(input int n, input int base, input logic [CW-1:0] c,
                          input bit toggle);
        int idx [2];
        int start [2];
        idx = '{0, 0};
        start = '{n_out[0], n_out[1]};
        for (int cyc = 0; cyc < 200; cyc++) begin
            for (int k = 0; k < 2; k++) begin
                in_valid[k]  = (idx[k] < n);
                in_ctrl[k]   = c;
                in_data[k]   = DW'(base + idx[k]);
                out_ready[k] = toggle ? ~cyc[0] : 1'b1;
            end
            tick();
            for (int k = 0; k < 2; k++) if (acc[k]) idx[k]++;
            if (idx[0] >= n && idx[1] >= n) break;
        end
        idle();
        repeat (4) tick();
        for (int k = 0; k < 2; k++) begin
            check("stream_accepted", k, DW'(idx[k]), DW'(n));
            check("stream_delivered", k, DW'(n_out[k] - start[k]), DW'(n));
        end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; n_out = '{0, 0};
        armed = 1'b0; rdy_q = '1; acc = '0;
        rst = 1'b1; flush = '0; in_valid = '1; out_ready = '1;
        in_ctrl = {3'b111, 3'b111}; in_data = '0;

        // Reset with a valid upstream word that must be ignored.
        tick();
        armed = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check("rst_out_valid", k, DW'(out_valid[k]), '0);
            check("rst_out_ctrl", k, DW'(out_ctrl[k]), '0);
            check("rst_out_data", k, out_data[k], '0);
            check("rst_occupancy", k, DW'(occ[k]), '0);
            check("rst_in_ready", k, DW'(in_ready[k]), DW'(1));
        end
        idle();
        tick();

        stream(8, 1, 3'b101, 1'b0);

        // Skid stall on lane 0: A, B, C with downstream stalling when A appears.
        in_valid[0] = 1'b1; in_ctrl[0] = 3'b011; in_data[0] = DW'('hA); out_ready[0] = 1'b1;
        tick();
        in_data[0] = DW'('hB); out_ready[0] = 1'b0;
        tick();
        check("skid_occ_two", 0, DW'(occ[0]), DW'(2));
        check("skid_in_ready_low", 0, DW'(in_ready[0]), '0);
        check("skid_hold_a", 0, out_data[0], DW'('hA));
        in_data[0] = DW'('hC);
        tick();
        check("skid_still_a", 0, out_data[0], DW'('hA));
        check("skid_still_two", 0, DW'(occ[0]), DW'(2));
        out_ready[0] = 1'b1;
        tick();
        check("skid_b_next", 0, out_data[0], DW'('hB));
        check("skid_ready_back", 0, DW'(in_ready[0]), DW'(1));
        tick();
        check("skid_c_last", 0, out_data[0], DW'('hC));
        idle();
        repeat (3) tick();

        // Fill (lane 0 to two entries), then flush with a concurrent word and out_xfer.
        in_valid = '1; in_ctrl = {3'b111, 3'b111}; out_ready = '0;
        in_data = {DW'('h11), DW'('h11)};
        tick();
        in_data = {DW'('h22), DW'('h22)};
        tick();
        check("pre_flush_occ", 0, DW'(occ[0]), DW'(2));
        flush = '1; out_ready = 2'b01; in_data = {DW'('hDEAD), DW'('hDEAD)};
        tick();
        for (int k = 0; k < 2; k++) begin
            check("flush_out_valid", k, DW'(out_valid[k]), '0);
            check("flush_out_ctrl", k, DW'(out_ctrl[k]), '0);
            check("flush_occupancy", k, DW'(occ[k]), '0);
            check("flush_in_ready", k, DW'(in_ready[k]), DW'(1));
        end
        idle();
        repeat (3) tick();

        stream(16, 'h100, 3'b110, 1'b1);

        // Random traffic with occasional mid-run resets.
        for (int cyc = 0; cyc < 10000; cyc++) begin
            rst = (cyc == 4000 || cyc == 7000);
            for (int k = 0; k < 2; k++) begin
                in_valid[k]  = ($urandom_range(0, 99) < 70);
                out_ready[k] = ($urandom_range(0, 99) < 60);
                flush[k]     = ($urandom_range(0, 99) < 5);
                in_ctrl[k]   = CW'($urandom);
                in_data[k]   = {$urandom, $urandom, 5'($urandom)};
            end
            tick();
        end
        rst = 1'b0;
        idle();
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, elastic pipeline stage register for the MIPS pipeline, used between any two stages (ID/EX, EX/MEM, MEM/WB). It carries a control field and a data field with valid/ready flow control, supports stall by backpressure and flush by bubble insertion, and optionally adds a one-entry skid buffer. The skid buffer breaks the combinational ready path between stages. A bubble always presents an all-zero control field, so write enables (RFWE, DMWE) are never asserted for an invalid slot.

## Interface
- CTRL_W, default 3: control-field width (e.g. RFWE, MtoRFSel, DMWE packed LSB-first).
- DATA_W, default 69: data-field width (e.g. DMdin 32 + ALUOut 32 + RFWA 5).
- SKID, default 1: 1 = two-entry skid mode with registered in_ready; 0 = single register with combinational in_ready.
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, synchronous and active-high.
- flush  in  1  discard all held entries this edge.
- in_valid  in  1  upstream slot valid.
- in_ready  out  1  stage can accept this cycle.
- in_ctrl  in  CTRL_W  upstream control field.
- in_data  in  DATA_W  upstream data field.
- out_valid  out  1  output slot valid.
- out_ready  in  1  downstream accepts this cycle.
- out_ctrl  out  CTRL_W  control field; forced 0 when out_valid=0.
- out_data  out  DATA_W  data field; unspecified when out_valid=0, must not be X after reset.
- occupancy  out  2  entries held (0..2; max 1 when SKID=0).

## Operation
- in_xfer = in_valid & in_ready & !flush & !RST.
- out_xfer = out_valid & out_ready.
- Storage:
  - main entry drives the outputs.
  - skid entry is present only when SKID=1.
- States (SKID=1): EMPTY (occ 0), ONE (main valid), TWO (main + skid valid).
  - EMPTY: in_xfer -> ONE, main <= in.
  - ONE: in_xfer & out_xfer -> ONE, main <= in. in_xfer only -> TWO, skid <= in. out_xfer only -> EMPTY.
  - TWO: out_xfer -> ONE, main <= skid. No input is accepted (in_ready=0).
- SKID=1: in_ready is a register, equal to (next state != TWO). There is no combinational path from out_ready to in_ready.
- SKID=0: the only states are EMPTY and ONE.
  - in_ready = !out_valid | out_ready (combinational).
  - ONE with in_xfer & out_xfer reloads main.
- Order is strictly FIFO. No entry is duplicated or dropped except by flush.
- Flush:
  - Any state -> EMPTY next edge; both valid bits cleared.
  - A concurrent in_valid is discarded.
  - A concurrent out_xfer still counts as consumed downstream.
  - in_ready = 1 the cycle after a flush.
- Bubble rule: out_ctrl = main_ctrl & {CTRL_W{out_valid}}. The control field stored for an invalid slot is also cleared to 0.
- Priority: RST > flush > transfers.

## Timing
- Reset values (edge with RST=1): state EMPTY, out_valid=0, out_ctrl=0, out_data=0, skid contents=0, occupancy=0, in_ready=1 (registered; inputs ignored while RST=1).
- Latency is 1 cycle: a word accepted at edge N is on out_* after edge N and before edge N+1.
- Throughput is 1 word/cycle with out_ready held high, in both modes.
- SKID=1 stall: out_ready falls at cycle N. At most one more word is accepted at edge N. in_ready is 0 from after edge N until one out_xfer occurs.
- Holding: while out_valid=1 and out_ready=0, out_ctrl and out_data are stable.
- Reset mid-operation: all held entries are lost, and no out_xfer is signalled on the reset edge.

## Test plan
- Reset/bubble: with RST=1 for 2 cycles and in_valid=1, in_ctrl=3'b111 -> after reset out_valid=0, out_ctrl=0, occupancy=0, in_ready=1.
- Streaming: send data 1..8 with ctrl=3'b101 on consecutive cycles, out_ready=1 -> outputs 1..8 each one cycle later, no gaps, occupancy stays 1.
- Skid stall (SKID=1):
  - Stimulus: stream A,B,C; out_ready=0 in the cycle A appears.
  - Expected: B is captured in skid and occupancy=2. in_ready=0 next cycle. C is held upstream. A stays stable.
  - After out_ready=1: A, B, C emerge in order.
- Flush in TWO:
  - Stimulus: fill to occupancy 2, then flush=1 with in_valid=1 and data 0xDEAD.
  - Expected next cycle: out_valid=0, out_ctrl=0, occupancy=0, in_ready=1. 0xDEAD never appears.
- SKID=0 backpressure: out_ready toggles 1,0,1,0 during a continuous stream -> in_ready tracks !out_valid|out_ready in the same cycle, and there is no loss or duplication over 16 words.
- Random: run 10k cycles of random in_valid, out_ready and flush (5%), both SKID values, checked against a scoreboard queue.
  - Order is preserved.
  - out_ctrl=0 whenever out_valid=0.
  - occupancy always matches the model.
